// File: rtl/ring_xfer_seq.sv
// Ring transfer sequencer: streams a command's beats from the local slide unit onto the ring
// and collects the same number of beats back. Define RING_XFER_SEQ_PERF_EN for the stall counter.
module ring_xfer_seq #(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned BeatWidth      = 16,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdWidth-1:0]   cluster_id_i,
  input  logic [IdWidth-1:0]   num_clusters_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [IdWidth-1:0]   cmd_shift_i,
  input  logic [BeatWidth-1:0] cmd_beats_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [DataWidth-1:0] src_data_i,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  output logic [DataWidth-1:0] ring_data_o,
  output logic [IdWidth-1:0]   ring_src_o,
  output logic [IdWidth-1:0]   ring_dst_o,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  input  logic [DataWidth-1:0] rx_data_i,
  output logic                 sink_valid_o,
  input  logic                 sink_ready_i,
  output logic [DataWidth-1:0] sink_data_o,
  output logic                 done_o,
  output logic [31:0]          perf_stall_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] MaxOut = 8'(MaxOutstanding);

  logic [1:0]           state_q, state_d;
  logic [BeatWidth-1:0] beats_q, sent_q, sent_d, rcvd_q, rcvd_d;
  logic [IdWidth-1:0]   shift_q;
  logic [7:0]           outst_q, outst_d;

  logic        run, bypass, tx_en, rx_en, byp_en;
  logic        tx_hs, rx_hs, byp_hs;
  logic [IdWidth:0] dst_sum;
  logic [31:0] ring_mask, dst_full;

  assign run    = (state_q == StRun);
  assign bypass = (shift_q == '0);
  assign tx_en  = run & ~bypass & (sent_q < beats_q) & (outst_q < MaxOut);
  assign rx_en  = run & ~bypass & (rcvd_q < beats_q);
  // Local bypass keeps sent and rcvd in lockstep, so sent alone bounds it.
  assign byp_en = run & bypass & (sent_q < beats_q);

  assign cmd_ready_o  = (state_q == StIdle);
  assign done_o       = (state_q == StDone);

  assign ring_valid_o = src_valid_i & tx_en;
  assign src_ready_o  = (ring_ready_i & tx_en) | (sink_ready_i & byp_en);
  assign ring_data_o  = src_data_i;
  assign rx_ready_o   = sink_ready_i & rx_en;
  assign sink_valid_o = (rx_valid_i & rx_en) | (src_valid_i & byp_en);
  assign sink_data_o  = bypass ? src_data_i : rx_data_i;

  assign dst_sum    = {1'b0, cluster_id_i} + {1'b0, shift_q};
  assign ring_mask  = (32'd1 << num_clusters_i) - 32'd1;
  assign dst_full   = 32'(dst_sum) & ring_mask;
  assign ring_src_o = cluster_id_i;
  assign ring_dst_o = dst_full[IdWidth-1:0];

  assign tx_hs  = ring_valid_o & ring_ready_i;
  assign rx_hs  = rx_valid_i & rx_ready_o;
  assign byp_hs = src_valid_i & sink_ready_i & byp_en;

  always_comb begin
    state_d = state_q;
    sent_d  = sent_q;
    rcvd_d  = rcvd_q;
    outst_d = outst_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StRun;
          sent_d  = '0;
          rcvd_d  = '0;
          outst_d = '0;
        end
      end
      StRun: begin
        if (tx_hs | byp_hs) sent_d = sent_q + BeatWidth'(1);
        if (rx_hs | byp_hs) rcvd_d = rcvd_q + BeatWidth'(1);
        // Beats from other clusters may arrive first; outst floors at zero.
        if (tx_hs && !rx_hs) begin
          outst_d = outst_q + 8'd1;
        end else if (rx_hs && !tx_hs && (outst_q != 8'd0)) begin
          outst_d = outst_q - 8'd1;
        end
        if ((sent_d == beats_q) && (rcvd_d == beats_q)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sent_q  <= '0;
      rcvd_q  <= '0;
      outst_q <= '0;
      beats_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      rcvd_q  <= rcvd_d;
      outst_q <= outst_d;
      if (cmd_valid_i && cmd_ready_o) begin
        beats_q <= cmd_beats_i;
        shift_q <= cmd_shift_i;
      end
    end
  end

`ifdef RING_XFER_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else if (run && src_valid_i && (outst_q == MaxOut)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_q;
`else
  assign perf_stall_o = '0;
`endif

endmodule
